// File: rtl/stage2_pkg.sv
// rtl/stage2_pkg.sv - shared types and constants for the stage-2 convolution sequencer
package stage2_pkg;
    localparam int NTAPS = 9;
    localparam int KW    = 4;
    localparam int PW    = 14;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // Tap 4 is the window centre, so the identity kernel passes the centre pixel through.
    localparam logic [NTAPS*KW-1:0] IDENTITY_KERNEL =
        {{(NTAPS-5)*KW{1'b0}}, KW'(1), {4*KW{1'b0}}};

    function automatic logic [KW-1:0] get_tap(input logic [NTAPS*KW-1:0] k, input int idx);
        return k[idx*KW +: KW];
    endfunction

    function automatic logic [NTAPS*KW-1:0] set_tap(input logic [NTAPS*KW-1:0] k,
                                                    input int idx,
                                                    input logic [KW-1:0] v);
        logic [NTAPS*KW-1:0] r;
        r = k;
        r[idx*KW +: KW] = v;
        return r;
    endfunction
endpackage

// File: rtl/stage2_kernel_regs.sv
// rtl/stage2_kernel_regs.sv - 3x3 coefficient register file with identity reset
module stage2_kernel_regs
    import stage2_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [3:0]          idx,
    input  logic [KW-1:0]       data,
    output logic [NTAPS*KW-1:0] kernel
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kernel <= IDENTITY_KERNEL;
        end else if (we && (idx < 4'(NTAPS))) begin
            kernel <= set_tap(kernel, int'(idx), data);
        end
    end
endmodule

// File: rtl/stage2_sequencer.sv
// rtl/stage2_sequencer.sv - frame FSM, window counter and two-stage operand/product pipeline
module stage2_sequencer #(
    parameter int WIDTH = 8,
    parameter int KW    = 4,
    parameter int PW    = 14,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_windows,
    input  logic               coef_we,
    input  logic [3:0]         coef_idx,
    input  logic [KW-1:0]      coef_data,
    input  logic               win_valid,
    output logic               win_ready,
    input  logic [9*WIDTH-1:0] win_pix,
    output logic [9*WIDTH-1:0] mul_a,
    output logic [8:0]         mul_a_valid,
    output logic [9*KW-1:0]    k_pixel,
    input  logic [9*PW-1:0]    mul_prod,
    input  logic [8:0]         mul_p_valid,
    output logic [9*PW-1:0]    prod_out,
    output logic               prod_valid,
    input  logic               prod_ready,
    output logic               stage3_start,
    output logic               busy,
    output logic               done,
    output logic               err
);
    import stage2_pkg::*;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               a_valid;
    logic [9*WIDTH-1:0] a_win;
    logic               b_valid;
    logic [9*PW-1:0]    b_prod;
    logic               first_flag;
    logic               b_load;
    logic               win_fire;

    stage2_kernel_regs u_kernel (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (coef_we && (state == IDLE)),
        .idx    (coef_idx),
        .data   (coef_data),
        .kernel (k_pixel)
    );

    assign b_load      = a_valid && (!b_valid || prod_ready);
    assign win_ready   = (state == RUN) && (cnt != '0) && (!a_valid || b_load);
    assign win_fire    = win_valid && win_ready;
    assign mul_a       = a_win;
    assign mul_a_valid = {NTAPS{a_valid}};
    assign prod_out    = b_prod;
    assign prod_valid  = b_valid;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            a_valid      <= 1'b0;
            a_win        <= '0;
            b_valid      <= 1'b0;
            b_prod       <= '0;
            first_flag   <= 1'b0;
            stage3_start <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            stage3_start <= 1'b0;
            done         <= 1'b0;

            if (win_fire) begin
                a_win   <= win_pix;
                a_valid <= 1'b1;
            end else if (b_load) begin
                a_valid <= 1'b0;
            end

            if (b_load) begin
                b_prod  <= mul_prod;
                b_valid <= 1'b1;
                if (!first_flag) begin
                    first_flag   <= 1'b1;
                    stage3_start <= 1'b1;
                end
            end else if (prod_ready) begin
                b_valid <= 1'b0;
            end

            if ((coef_we && (state != IDLE)) || (a_valid && (mul_p_valid != '1))) begin
                err <= 1'b1;
            end

            // done is registered on entry to DONE so it is high exactly while state==DONE.
            case (state)
                IDLE: if (start) begin
                    cnt        <= num_windows;
                    err        <= 1'b0;
                    first_flag <= 1'b0;
                    if (num_windows == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: if (win_fire) begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= DRAIN;
                end
                DRAIN: if (!a_valid && !b_valid) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
